// File: rtl/ctu_mask_id_pkg.sv
// Shared constants for the CTU mask-ID capture block: IDCODE field layout,
// CSR read-data bit positions, lock FSM states and the IDCODE word builder.
package ctu_mask_id_pkg;

    localparam int IDC_VER_W     = 4;
    localparam int IDC_VER_LSB   = 28;
    localparam int IDC_PART_W    = 16;
    localparam int IDC_PART_LSB  = 12;
    localparam int IDC_MANUF_W   = 11;
    localparam int IDC_MANUF_LSB = 1;
    localparam int IDC_LSB       = 0;

    localparam int CSR_REV_LSB   = 0;
    localparam int CSR_REV_W     = 4;
    localparam int CSR_VALID_BIT = 4;
    localparam int CSR_ERR_BIT   = 5;

    typedef enum logic {
        SETTLE,
        LOCKED
    } state_e;

    function automatic logic [31:0] idcode_word(
        input logic [IDC_VER_W-1:0]   ver,
        input logic [IDC_PART_W-1:0]  part,
        input logic [IDC_MANUF_W-1:0] manuf
    );
        logic [31:0] w;
        w = '0;
        w[IDC_VER_LSB   +: IDC_VER_W]   = ver;
        w[IDC_PART_LSB  +: IDC_PART_W]  = part;
        w[IDC_MANUF_LSB +: IDC_MANUF_W] = manuf;
        w[IDC_LSB]                      = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/ctu_idcode_shreg.sv
// 32-bit JTAG data register with parallel capture (priority) and LSB-first shift.
// Ports: clk, rst (sync, active-high), load_i/din_i capture, shift_i/tdi_i shift, tdo_o = sr[0].
module ctu_idcode_shreg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic [31:0] din_i,
    input  logic        tdi_i,
    output logic        tdo_o
);

    logic [31:0] sr_q;
    logic [31:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = din_i;
        end else if (shift_i) begin
            sr_d = {tdi_i, sr_q[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= RESET_VAL;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign tdo_o = sr_q[0];

endmodule

// File: rtl/ctu_mask_id_capture.sv
// Qualifies the mask-ID cell output, latches it as die revision and exposes it
// via IDCODE (tdo) and a CSR read port. Optional CTU_MASK_ID_MISMATCH_EN adds
// a sticky post-lock mismatch flag. Ports: clk, rst, mask_id, TAP controls
// (idcode_sel/capture_dr/shift_dr/tdi/tdo), id_valid, rev_id, CSR req/ack/data, mask_id_err.
module ctu_mask_id_capture
    import ctu_mask_id_pkg::*;
#(
    parameter logic [15:0] PART_NUM   = 16'h0000,
    parameter logic [10:0] MANUF_ID   = 11'h03E,
    parameter int          STABLE_CNT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mask_id,
    input  logic        idcode_sel,
    input  logic        capture_dr,
    input  logic        shift_dr,
    input  logic        tdi,
    output logic        tdo,
    output logic        id_valid,
    output logic [3:0]  rev_id,
    input  logic        csr_rd_req,
    output logic        csr_rd_ack,
    output logic [31:0] csr_rd_data,
    output logic        mask_id_err
);

    localparam logic [7:0] LOCK_CNT = 8'(STABLE_CNT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  mask_id_q;
    logic [3:0]  rev_q, rev_d;
    logic        valid_q, valid_d;
    logic        ack_q, ack_d;
    logic        err_bit;
    logic [31:0] csr_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        valid_d = valid_q;
        unique case (state_q)
            SETTLE: begin
                if (mask_id == mask_id_q) begin
                    if (cnt_q == LOCK_CNT) begin
                        state_d = LOCKED;
                        rev_d   = mask_id_q;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            LOCKED: begin
            end
        endcase
    end

    // Ack is self-clearing so a held request is served every other cycle.
    assign ack_d = csr_rd_req && valid_q && !ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SETTLE;
            cnt_q     <= '0;
            mask_id_q <= '0;
            rev_q     <= '0;
            valid_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_id_q <= mask_id;
            rev_q     <= rev_d;
            valid_q   <= valid_d;
            ack_q     <= ack_d;
        end
    end

`ifdef CTU_MASK_ID_MISMATCH_EN
    logic err_q, err_d;

    assign err_d = err_q | ((state_q == LOCKED) && (mask_id_q != rev_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_bit = err_q;
`else
    assign err_bit = 1'b0;
`endif

    always_comb begin
        csr_word = '0;
        if (ack_q) begin
            csr_word[CSR_REV_LSB +: CSR_REV_W] = rev_q;
            csr_word[CSR_VALID_BIT]            = valid_q;
            csr_word[CSR_ERR_BIT]              = err_bit;
        end
    end

    ctu_idcode_shreg #(
        .RESET_VAL (idcode_word(4'h0, PART_NUM, MANUF_ID))
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (idcode_sel && capture_dr),
        .shift_i (idcode_sel && shift_dr),
        .din_i   (idcode_word(rev_q, PART_NUM, MANUF_ID)),
        .tdi_i   (tdi),
        .tdo_o   (tdo)
    );

    assign id_valid    = valid_q;
    assign rev_id      = rev_q;
    assign csr_rd_ack  = ack_q;
    assign csr_rd_data = csr_word;
    assign mask_id_err = err_bit;

endmodule
